// File: rtl/noobs_cpu_core.sv
// noobs_cpu_core: 8-bit multicycle CPU, one instruction byte per FETCH/CAPTURE pair, 4x8-bit registers.
// Optional simulation checks are compiled in with NOOBS_CPU_ASSERT_EN.
module noobs_cpu_core #(
  parameter logic [11:0] PC_RESET = 12'h000
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic [7:0]  i_data,
  output logic [11:0] i_addr,
  input  logic [7:0]  m_rd_data,
  output logic [7:0]  m_wr_data,
  output logic [11:0] m_addr,
  output logic        m_rd,
  output logic        m_wr,
  output logic        m_en,
  output logic        halted
);

  typedef enum logic [2:0] {S_FETCH, S_CAPTURE, S_MRD, S_MCAP, S_MWR, S_HALT} state_t;

  state_t          state_r;
  logic [11:0]     pc_r;
  logic [11:0]     m_addr_r;
  logic [7:0]      op_r;
  logic [3:0]      b2_r;
  logic [7:0]      m_wr_data_r;
  logic [1:0]      idx_r;
  logic [3:0][7:0] regs_r;
  logic            z_r;
  logic            c_r;
  logic            halted_r;
  logic            m_rd_r;
  logic            m_wr_r;
  logic            m_en_r;

  logic [7:0]  cur_op_s;
  logic [3:0]  op_s;
  logic [1:0]  rd_idx_s;
  logic [1:0]  rs_idx_s;
  logic [7:0]  rd_val_s;
  logic [7:0]  rs_val_s;
  logic [8:0]  sum_s;
  logic [7:0]  alu_res_s;
  logic        alu_c_s;
  logic        alu_wr_s;
  logic        flags_wr_s;
  logic        last_s;
  logic [11:0] a12_s;

  function automatic logic [1:0] op_len(input logic [3:0] op);
    case (op)
      4'h7:                         op_len = 2'd2;
      4'h8, 4'h9, 4'hA, 4'hB, 4'hC: op_len = 2'd3;
      default:                      op_len = 2'd1;
    endcase
  endfunction

  // The opcode byte is still on i_data while its own CAPTURE cycle runs
  assign cur_op_s = (idx_r == 2'd0) ? i_data : op_r;
  assign op_s     = cur_op_s[7:4];
  assign rd_idx_s = cur_op_s[3:2];
  assign rs_idx_s = cur_op_s[1:0];
  assign rd_val_s = regs_r[rd_idx_s];
  assign rs_val_s = regs_r[rs_idx_s];
  assign last_s   = (idx_r == (op_len(op_s) - 2'd1));
  assign a12_s    = {b2_r, i_data};

  // ALU result, carry/borrow and write-enable decode for the instruction being completed
  always_comb begin
    sum_s      = 9'h000;
    alu_res_s  = 8'h00;
    alu_c_s    = c_r;
    alu_wr_s   = 1'b0;
    flags_wr_s = 1'b0;
    case (op_s)
      4'h1: begin alu_res_s = rs_val_s; alu_wr_s = 1'b1; end
      4'h2: begin
        sum_s = {1'b0, rd_val_s} + {1'b0, rs_val_s};
        alu_res_s = sum_s[7:0]; alu_c_s = sum_s[8]; alu_wr_s = 1'b1; flags_wr_s = 1'b1;
      end
      4'h3, 4'hD: begin
        sum_s = {1'b0, rd_val_s} - {1'b0, rs_val_s};
        alu_res_s = sum_s[7:0]; alu_c_s = sum_s[8]; flags_wr_s = 1'b1;
        alu_wr_s = (op_s == 4'h3) ? 1'b1 : 1'b0;
      end
      4'h4: begin alu_res_s = rd_val_s & rs_val_s; alu_c_s = 1'b0; alu_wr_s = 1'b1; flags_wr_s = 1'b1; end
      4'h5: begin alu_res_s = rd_val_s | rs_val_s; alu_c_s = 1'b0; alu_wr_s = 1'b1; flags_wr_s = 1'b1; end
      4'h6: begin alu_res_s = rd_val_s ^ rs_val_s; alu_c_s = 1'b0; alu_wr_s = 1'b1; flags_wr_s = 1'b1; end
      4'h7: begin alu_res_s = i_data; alu_wr_s = 1'b1; end
      default: begin alu_res_s = 8'h00; alu_wr_s = 1'b0; end
    endcase
  end

  // Main sequencer: fetch/capture bytes, execute, drive the registered data-memory strobes
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_r     <= S_FETCH;
      pc_r        <= PC_RESET;
      op_r        <= 8'h00;
      b2_r        <= 4'h0;
      idx_r       <= 2'd0;
      regs_r      <= '0;
      z_r         <= 1'b0;
      c_r         <= 1'b0;
      halted_r    <= 1'b0;
      m_addr_r    <= 12'h000;
      m_wr_data_r <= 8'h00;
      m_rd_r      <= 1'b0;
      m_wr_r      <= 1'b0;
      m_en_r      <= 1'b0;
    end else begin
      case (state_r)
        S_FETCH: state_r <= S_CAPTURE;
        S_CAPTURE: begin
          pc_r    <= pc_r + 12'd1;
          state_r <= S_FETCH;
          if (idx_r == 2'd0) op_r <= i_data;
          if (idx_r == 2'd1) b2_r <= i_data[3:0];
          if (!last_s) begin
            idx_r <= idx_r + 2'd1;
          end else begin
            idx_r <= 2'd0;
            if (alu_wr_s) regs_r[rd_idx_s] <= alu_res_s;
            if (flags_wr_s) begin
              z_r <= (alu_res_s == 8'h00);
              c_r <= alu_c_s;
            end
            case (op_s)
              4'h8: begin m_addr_r <= a12_s; m_rd_r <= 1'b1; m_en_r <= 1'b1; state_r <= S_MRD; end
              4'h9: begin
                m_addr_r <= a12_s; m_wr_data_r <= rd_val_s;
                m_wr_r <= 1'b1; m_en_r <= 1'b1; state_r <= S_MWR;
              end
              4'hA: pc_r <= a12_s;
              4'hB: if (z_r) pc_r <= a12_s;
              4'hC: if (c_r) pc_r <= a12_s;
              4'hF: begin halted_r <= 1'b1; state_r <= S_HALT; end
              default: state_r <= S_FETCH;
            endcase
          end
        end
        S_MRD: begin m_rd_r <= 1'b0; m_en_r <= 1'b0; state_r <= S_MCAP; end
        S_MCAP: begin regs_r[op_r[3:2]] <= m_rd_data; state_r <= S_FETCH; end
        S_MWR: begin m_wr_r <= 1'b0; m_en_r <= 1'b0; state_r <= S_FETCH; end
        S_HALT: state_r <= S_HALT;
        default: state_r <= S_FETCH;
      endcase
    end
  end

  assign i_addr    = pc_r;
  assign m_addr    = m_addr_r;
  assign m_wr_data = m_wr_data_r;
  assign m_rd      = m_rd_r;
  assign m_wr      = m_wr_r;
  assign m_en      = m_en_r;
  assign halted    = halted_r;

`ifdef NOOBS_CPU_ASSERT_EN
  // Simulation-only sanity checks on the instruction stream and data bus
  always_ff @(posedge clk) begin
    if (reset_) begin
      if (m_rd_r && m_wr_r) $error("noobs_cpu_core: m_rd and m_wr both high");
      if ((state_r == S_CAPTURE) && $isunknown(i_data)) $error("noobs_cpu_core: X on i_data in CAPTURE");
      if ((state_r == S_CAPTURE) && (idx_r == 2'd0) && (i_data[7:4] == 4'hE))
        $error("noobs_cpu_core: reserved opcode E at %h", pc_r);
    end
  end
`endif

endmodule

// File: tb/tb_noobs_cpu_core.sv
// Directed self-checking bench for noobs_cpu_core with synchronous instruction/data memory models.
module tb_noobs_cpu_core;
  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic [11:0] i_addr;
  logic [7:0]  m_rd_data = 8'h00;
  logic [7:0]  m_wr_data;
  logic [11:0] m_addr;
  logic        m_rd, m_wr, m_en, halted;

  logic [7:0]  imem [0:4095];
  logic [7:0]  dmem [0:4095];
  logic        pk_req = 1'b0, pk_clr = 1'b0;
  logic [11:0] pk_addr = 12'h000;
  logic [7:0]  pk_data = 8'h00;
  int rd_cnt = 0, wr_cnt = 0, both_err = 0, strobe_err = 0, en_err = 0;
  logic prev_rd = 1'b0, prev_wr = 1'b0;
  int n_checks = 0, n_fails = 0;

  noobs_cpu_core #(.PC_RESET(12'h000)) dut (
    .clk(clk), .reset_(reset_), .i_data(i_data), .i_addr(i_addr), .m_rd_data(m_rd_data),
    .m_wr_data(m_wr_data), .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr), .m_en(m_en), .halted(halted));

  always #5 clk = ~clk;

  // Memory models: one-cycle read latency, writes on strobe, preload port for the bench
  always @(posedge clk) begin
    i_data <= imem[i_addr];
    if (pk_clr) begin
      for (int k = 0; k < 4096; k++) dmem[k] <= 8'h00;
    end else if (pk_req) dmem[pk_addr] <= pk_data;
    else if (m_en && m_wr) dmem[m_addr] <= m_wr_data;
    if (m_en && m_rd) m_rd_data <= dmem[m_addr];
    if (m_en && m_rd) rd_cnt <= rd_cnt + 1;
    if (m_en && m_wr) wr_cnt <= wr_cnt + 1;
  end

  // Bus-rule monitor sampled mid-cycle
  always @(negedge clk) begin
    if (m_rd && m_wr) both_err <= both_err + 1;
    if ((m_rd && prev_rd) || (m_wr && prev_wr)) strobe_err <= strobe_err + 1;
    if (m_en !== (m_rd | m_wr)) en_err <= en_err + 1;
    prev_rd <= m_rd;
    prev_wr <= m_wr;
  end

  task automatic clear_mems();
    for (int k = 0; k < 4096; k++) imem[k] = 8'h00;
    pk_clr = 1'b1; @(posedge clk); #1 pk_clr = 1'b0;
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    pk_addr = a; pk_data = d; pk_req = 1'b1; @(posedge clk); #1 pk_req = 1'b0;
  endtask

  task automatic run_prog(input int budget, output int cycles);
    reset_ = 1'b0;
    @(negedge clk); @(negedge clk);
    reset_ = 1'b1;
    cycles = 0;
    while (halted !== 1'b1 && cycles < budget) begin @(negedge clk); cycles++; end
  endtask

  task automatic load_add_prog();
    logic [7:0] p [0:14] = '{8'h70,8'h05,8'h74,8'h03,8'h21,8'hB0,8'h00,8'h80,
                             8'hC0,8'h00,8'h80,8'h90,8'h00,8'h08,8'hF0};
    clear_mems();
    for (int k = 0; k < 15; k++) imem[k] = p[k];
    imem[12'h080] = 8'hF0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if ({i_addr, m_addr, m_wr_data, m_rd, m_wr, m_en, halted} !== 36'h0) begin
      n_fails++; $display("FAIL reset_outputs got i_addr=%h m_addr=%h wd=%h rd=%b wr=%b en=%b h=%b exp all 0",
        i_addr, m_addr, m_wr_data, m_rd, m_wr, m_en, halted); end
  endtask

  task automatic test_add_store();
    int cyc, w0;
    load_add_prog();
    w0 = wr_cnt;
    run_prog(200, cyc);
    n_checks++; if (halted !== 1'b1) begin n_fails++; $display("FAIL add_halted got %b exp 1", halted); end
    n_checks++; if (cyc !== 31) begin n_fails++; $display("FAIL add_cycles got %0d exp 31", cyc); end
    n_checks++; if (dmem[12'h008] !== 8'h08) begin n_fails++; $display("FAIL add_mem8 got %h exp 08", dmem[12'h008]); end
    n_checks++; if (wr_cnt - w0 !== 1) begin n_fails++; $display("FAIL add_writes got %0d exp 1", wr_cnt - w0); end
    n_checks++; if (i_addr !== 12'h00F) begin n_fails++; $display("FAIL add_pc got %h exp 00f", i_addr); end
  endtask

  task automatic test_halt_hold();
    logic [33:0] snap;
    int r0, w0;
    snap = {i_addr, m_addr, m_wr_data, m_rd, m_wr};
    r0 = rd_cnt; w0 = wr_cnt;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_checks++; if ({i_addr, m_addr, m_wr_data, m_rd, m_wr} !== snap || m_en !== 1'b0 || halted !== 1'b1) begin
        n_fails++; $display("FAIL halt_hold cyc%0d got %h en=%b h=%b exp %h en=0 h=1",
          k, {i_addr, m_addr, m_wr_data, m_rd, m_wr}, m_en, halted, snap); end
    end
    n_checks++; if (rd_cnt - r0 + wr_cnt - w0 !== 0) begin
      n_fails++; $display("FAIL halt_bus got %0d accesses exp 0", rd_cnt - r0 + wr_cnt - w0); end
  endtask

  task automatic test_jz_jc_taken();
    logic [7:0] p [0:19] = '{8'h70,8'hFF,8'h74,8'h01,8'h21,8'hB0,8'h00,8'h0C,8'h90,8'h00,
                             8'h09,8'hF0,8'hC0,8'h00,8'h10,8'hF0,8'h90,8'h00,8'h0C,8'hF0};
    int cyc, w0;
    clear_mems();
    for (int k = 0; k < 20; k++) imem[k] = p[k];
    poke(12'h009, 8'hAA); poke(12'h00C, 8'h55);
    w0 = wr_cnt;
    run_prog(200, cyc);
    n_checks++; if (cyc !== 31) begin n_fails++; $display("FAIL jz_cycles got %0d exp 31", cyc); end
    n_checks++; if (dmem[12'h009] !== 8'hAA) begin n_fails++; $display("FAIL jz_mem9 got %h exp aa", dmem[12'h009]); end
    n_checks++; if (dmem[12'h00C] !== 8'h00) begin n_fails++; $display("FAIL jz_r0 got %h exp 00", dmem[12'h00C]); end
    n_checks++; if (wr_cnt - w0 !== 1) begin n_fails++; $display("FAIL jz_writes got %0d exp 1", wr_cnt - w0); end
    n_checks++; if (i_addr !== 12'h014) begin n_fails++; $display("FAIL jz_pc got %h exp 014", i_addr); end
  endtask

  task automatic test_ld_xor();
    logic [7:0] p [0:17] = '{8'h88,8'h00,8'h0A,8'h6A,8'h98,8'h00,8'h0B,8'hB0,8'h00,
                             8'h0C,8'hF0,8'hF0,8'h74,8'h77,8'h94,8'h00,8'h0E,8'hF0};
    int cyc, r0, w0;
    clear_mems();
    for (int k = 0; k < 18; k++) imem[k] = p[k];
    poke(12'h00A, 8'h3C); poke(12'h00B, 8'hFF);
    r0 = rd_cnt; w0 = wr_cnt;
    run_prog(200, cyc);
    n_checks++; if (cyc !== 36) begin n_fails++; $display("FAIL ldx_cycles got %0d exp 36", cyc); end
    n_checks++; if (dmem[12'h00B] !== 8'h00) begin n_fails++; $display("FAIL ldx_memB got %h exp 00", dmem[12'h00B]); end
    n_checks++; if (dmem[12'h00E] !== 8'h77) begin n_fails++; $display("FAIL ldx_zflag got %h exp 77", dmem[12'h00E]); end
    n_checks++; if (rd_cnt - r0 !== 1) begin n_fails++; $display("FAIL ldx_reads got %0d exp 1", rd_cnt - r0); end
    n_checks++; if (wr_cnt - w0 !== 2) begin n_fails++; $display("FAIL ldx_writes got %0d exp 2", wr_cnt - w0); end
    n_checks++; if (m_addr !== 12'h00E) begin n_fails++; $display("FAIL ldx_maddr got %h exp 00e", m_addr); end
  endtask

  task automatic test_ld_data();
    logic [7:0] p [0:6] = '{8'h8C,8'h00,8'h20,8'h9C,8'h00,8'h21,8'hF0};
    int cyc;
    clear_mems();
    for (int k = 0; k < 7; k++) imem[k] = p[k];
    poke(12'h020, 8'h5A);
    run_prog(100, cyc);
    n_checks++; if (cyc !== 17) begin n_fails++; $display("FAIL ld_cycles got %0d exp 17", cyc); end
    n_checks++; if (dmem[12'h021] !== 8'h5A) begin n_fails++; $display("FAIL ld_data got %h exp 5a", dmem[12'h021]); end
  endtask

  task automatic test_loop();
    logic [7:0] p [0:14] = '{8'h74,8'h01,8'h7C,8'h02,8'h3D,8'hB0,8'h00,8'h0B,
                             8'hA0,8'h00,8'h04,8'h9C,8'h00,8'h30,8'hF0};
    int cyc;
    clear_mems();
    for (int k = 0; k < 15; k++) imem[k] = p[k];
    poke(12'h030, 8'hEE);
    run_prog(300, cyc);
    n_checks++; if (halted !== 1'b1) begin n_fails++; $display("FAIL loop_halted got %b exp 1", halted); end
    n_checks++; if (cyc !== 39) begin n_fails++; $display("FAIL loop_cycles got %0d exp 39", cyc); end
    n_checks++; if (dmem[12'h030] !== 8'h00) begin n_fails++; $display("FAIL loop_r3 got %h exp 00", dmem[12'h030]); end
  endtask

  task automatic test_logic_ops();
    logic [7:0] p [0:23] = '{8'h70,8'hF0,8'h74,8'h3C,8'h18,8'h49,8'h98,8'h00,8'h40,8'h51,8'h90,8'h00,
                             8'h41,8'hE0,8'hD4,8'hC0,8'h00,8'h14,8'hF0,8'hF0,8'h94,8'h00,8'h42,8'hF0};
    int cyc;
    clear_mems();
    for (int k = 0; k < 24; k++) imem[k] = p[k];
    run_prog(300, cyc);
    n_checks++; if (cyc !== 47) begin n_fails++; $display("FAIL logic_cycles got %0d exp 47", cyc); end
    n_checks++; if (dmem[12'h040] !== 8'h30) begin n_fails++; $display("FAIL logic_and got %h exp 30", dmem[12'h040]); end
    n_checks++; if (dmem[12'h041] !== 8'hFC) begin n_fails++; $display("FAIL logic_or got %h exp fc", dmem[12'h041]); end
    n_checks++; if (dmem[12'h042] !== 8'h3C) begin n_fails++; $display("FAIL logic_cmp got %h exp 3c", dmem[12'h042]); end
  endtask

  task automatic test_pc_wrap();
    int cyc;
    clear_mems();
    imem[0] = 8'hA0; imem[1] = 8'h0F; imem[2] = 8'hFE;
    imem[12'hFFE] = 8'h00; imem[12'hFFF] = 8'hF0;
    run_prog(100, cyc);
    n_checks++; if (cyc !== 10) begin n_fails++; $display("FAIL wrap_cycles got %0d exp 10", cyc); end
    n_checks++; if (i_addr !== 12'h000) begin n_fails++; $display("FAIL wrap_pc got %h exp 000", i_addr); end
  endtask

  task automatic test_reset_mid_store();
    int cyc;
    load_add_prog();
    poke(12'h008, 8'hEE);
    reset_ = 1'b0;
    @(negedge clk); @(negedge clk);
    reset_ = 1'b1;
    cyc = 0;
    while (m_wr !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    n_checks++; if (m_wr !== 1'b1) begin n_fails++; $display("FAIL rst_find_mwr got %b exp 1", m_wr); end
    reset_ = 1'b0;
    #1;
    n_checks++; if ({i_addr, m_addr, m_wr_data, m_rd, m_wr, m_en, halted} !== 36'h0) begin
      n_fails++; $display("FAIL rst_mid_outputs got i_addr=%h m_addr=%h wd=%h rd=%b wr=%b en=%b exp all 0",
        i_addr, m_addr, m_wr_data, m_rd, m_wr, m_en); end
    @(posedge clk); #1;
    n_checks++; if (dmem[12'h008] !== 8'hEE) begin n_fails++; $display("FAIL rst_no_write got %h exp ee", dmem[12'h008]); end
    @(negedge clk);
    reset_ = 1'b1;
    @(negedge clk); @(negedge clk);
    n_checks++; if (i_addr !== 12'h001) begin n_fails++; $display("FAIL rst_refetch got %h exp 001", i_addr); end
    cyc = 2;
    while (halted !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    n_checks++; if (cyc !== 31) begin n_fails++; $display("FAIL rst_rerun_cycles got %0d exp 31", cyc); end
    n_checks++; if (dmem[12'h008] !== 8'h08) begin n_fails++; $display("FAIL rst_rerun_mem got %h exp 08", dmem[12'h008]); end
  endtask

  task automatic test_bus_rules();
    n_checks++; if (both_err !== 0) begin n_fails++; $display("FAIL bus_rd_wr_overlap got %0d exp 0", both_err); end
    n_checks++; if (strobe_err !== 0) begin n_fails++; $display("FAIL bus_strobe_width got %0d exp 0", strobe_err); end
    n_checks++; if (en_err !== 0) begin n_fails++; $display("FAIL bus_en_match got %0d exp 0", en_err); end
  endtask

  initial begin
    test_reset();
    test_add_store();
    test_halt_hold();
    test_jz_jc_taken();
    test_ld_xor();
    test_ld_data();
    test_loop();
    test_logic_ops();
    test_pc_wrap();
    test_reset_mid_store();
    test_bus_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
